// File: rtl/timp_load_scheduler.sv
// Arbitrates two requesters (A: manual set, B: sync) onto the time counter's two
// load ports, range-checks the time, pulses the load and verifies it by readback.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   req_a, ore_a, minute_a        requester A: level request + requested hh:mm
//   req_b, ore_b, minute_b        requester B: level request + requested hh:mm
//   ack_a, ack_b                  one-cycle pulse: load done and verified
//   err_a, err_b                  one-cycle pulse: rejected value or verify failure
//   busy                          high whenever the FSM is not idle
//   timp_ore1, timp_minute1       held hh:mm for counter port 1 (A)
//   load_1                        counter port 1 load strobe
//   timp_ore2, timp_minute2       held hh:mm for counter port 2 (B)
//   load_2                        counter port 2 load strobe
//   ore, minute                   counter readback
module timp_load_scheduler #(
    parameter int LOAD_LAT  = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [4:0] ore_a,
    input  logic [5:0] minute_a,
    input  logic       req_b,
    input  logic [4:0] ore_b,
    input  logic [5:0] minute_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       err_a,
    output logic       err_b,
    output logic       busy,
    output logic [4:0] timp_ore1,
    output logic [5:0] timp_minute1,
    output logic       load_1,
    output logic [4:0] timp_ore2,
    output logic [5:0] timp_minute2,
    output logic       load_2,
    input  logic [4:0] ore,
    input  logic [5:0] minute
);

    localparam int WW = $clog2(LOAD_LAT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          sel_b;
    logic          last_b;
    logic [4:0]    hold_ore;
    logic [5:0]    hold_min;
    logic [RW-1:0] retry;
    logic [WW-1:0] wait_cnt;

    logic       any_req;
    logic       pick_b;
    logic [4:0] pick_ore;
    logic [5:0] pick_min;
    logic       pick_ok;
    logic [4:0] ore_inc;
    logic       match;

    assign any_req  = req_a | req_b;
    // On a conflict the side that was not served last wins.
    assign pick_b   = req_b & (~req_a | ~last_b);
    assign pick_ore = pick_b ? ore_b : ore_a;
    assign pick_min = pick_b ? minute_b : minute_a;
    assign pick_ok  = (pick_ore <= 5'd23) && (pick_min <= 6'd59);

    // The counter may already have ticked once since the load landed,
    // including the carry from :59 into the next hour.
    assign ore_inc = (hold_ore == 5'd23) ? 5'd0 : hold_ore + 5'd1;
    assign match   = ((ore == hold_ore) &&
                      ((minute == hold_min) ||
                       ((hold_min != 6'd59) && (minute == hold_min + 6'd1)))) ||
                     ((hold_min == 6'd59) && (minute == 6'd0) && (ore == ore_inc));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            sel_b        <= 1'b0;
            last_b       <= 1'b1;
            hold_ore     <= '0;
            hold_min     <= '0;
            retry        <= '0;
            wait_cnt     <= '0;
            timp_ore1    <= '0;
            timp_minute1 <= '0;
            timp_ore2    <= '0;
            timp_minute2 <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_IDLE && any_req) begin
                sel_b    <= pick_b;
                hold_ore <= pick_ore;
                hold_min <= pick_min;
                if (pick_b) begin
                    timp_ore2    <= pick_ore;
                    timp_minute2 <= pick_min;
                end else begin
                    timp_ore1    <= pick_ore;
                    timp_minute1 <= pick_min;
                end
            end
            if (state == S_CHECK && state_nx == S_LOAD) begin
                retry <= retry + RW'(1);
            end
            if (state == S_DONE || state == S_FAIL) begin
                retry  <= '0;
                last_b <= sel_b;
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        load_1   = 1'b0;
        load_2   = 1'b0;
        ack_a    = 1'b0;
        ack_b    = 1'b0;
        err_a    = 1'b0;
        err_b    = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = pick_ok ? S_LOAD : S_FAIL;
                end
            end
            S_LOAD: begin
                load_1   = ~sel_b;
                load_2   = sel_b;
                state_nx = (LOAD_LAT > 1) ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match) begin
                    state_nx = S_DONE;
                end else if (retry < RETRY_MAX) begin
                    state_nx = S_LOAD;
                end else begin
                    state_nx = S_FAIL;
                end
            end
            S_DONE: begin
                ack_a    = ~sel_b;
                ack_b    = sel_b;
                state_nx = S_IDLE;
            end
            S_FAIL: begin
                err_a    = ~sel_b;
                err_b    = sel_b;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_timp_load_scheduler.sv
// Scoreboard bench for timp_load_scheduler: stimulus pushes expected
// load/ack/err events, a monitor pops and compares them as the DUT emits them.
module tb_timp_load_scheduler;

    localparam int LOAD_LAT = 2;
    localparam int K_L1   = 1;
    localparam int K_L2   = 2;
    localparam int K_ACKA = 3;
    localparam int K_ACKB = 4;
    localparam int K_ERRA = 5;
    localparam int K_ERRB = 6;

    logic       clock;
    logic       reset;
    logic       req_a;
    logic [4:0] ore_a;
    logic [5:0] minute_a;
    logic       req_b;
    logic [4:0] ore_b;
    logic [5:0] minute_b;
    logic       ack_a;
    logic       ack_b;
    logic       err_a;
    logic       err_b;
    logic       busy;
    logic [4:0] timp_ore1;
    logic [5:0] timp_minute1;
    logic       load_1;
    logic [4:0] timp_ore2;
    logic [5:0] timp_minute2;
    logic       load_2;
    logic [4:0] ore;
    logic [5:0] minute;

    typedef struct {
        int kind;
        int o;
        int m;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  total;
    int  bad;
    int  cyc;
    bit  stuck;
    bit  tick_mode;
    bit  tick_pend;

    timp_load_scheduler #(.LOAD_LAT(LOAD_LAT), .MAX_RETRY(2)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .ore_a(ore_a), .minute_a(minute_a),
        .req_b(req_b), .ore_b(ore_b), .minute_b(minute_b),
        .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
        .busy(busy),
        .timp_ore1(timp_ore1), .timp_minute1(timp_minute1), .load_1(load_1),
        .timp_ore2(timp_ore2), .timp_minute2(timp_minute2), .load_2(load_2),
        .ore(ore), .minute(minute)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever @(posedge clock) cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int o, input int m, input int c);
        ev_t e;
        e.kind = kind;
        e.o = o;
        e.m = m;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input int o, input int m);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == K_L1 || kind == K_L2) begin
                chk("load_ore", o, e.o);
                chk("load_minute", m, e.m);
            end
            if (e.c >= 0) chk("event_cycle", cyc, e.c);
        end
    endtask

    // Monitor: every strobe/pulse the DUT shows is matched against the scoreboard.
    initial begin
        forever @(negedge clock) begin
            if (load_1 && load_2) chk("load_exclusive", 1, 0);
            if (load_1) see(K_L1, int'(timp_ore1), int'(timp_minute1));
            if (load_2) see(K_L2, int'(timp_ore2), int'(timp_minute2));
            if (ack_a) see(K_ACKA, 0, 0);
            if (ack_b) see(K_ACKB, 0, 0);
            if (err_a) see(K_ERRA, 0, 0);
            if (err_b) see(K_ERRB, 0, 0);
        end
    end

    // Time counter model: loads on strobe unless stuck; may tick once after a load.
    initial begin
        ore = 5'd0;
        minute = 6'd0;
        tick_pend = 1'b0;
        forever @(negedge clock) begin
            if (tick_pend) begin
                tick_pend = 1'b0;
                if (minute == 6'd59) begin
                    minute = 6'd0;
                    ore = (ore == 5'd23) ? 5'd0 : ore + 5'd1;
                end else begin
                    minute = minute + 6'd1;
                end
            end
            if (!stuck && load_1) begin
                ore = timp_ore1;
                minute = timp_minute1;
                tick_pend = tick_mode;
            end else if (!stuck && load_2) begin
                ore = timp_ore2;
                minute = timp_minute2;
                tick_pend = tick_mode;
            end
        end
    end

    task automatic run_a(input logic [4:0] o, input logic [5:0] m);
        bit done;
        done = 1'b0;
        ore_a = o;
        minute_a = m;
        req_a = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (ack_a || err_a) done = 1'b1;
        end
        req_a = 1'b0;
        chk("a_completed", int'(done), 1);
    endtask

    task automatic run_b(input logic [4:0] o, input logic [5:0] m);
        bit done;
        done = 1'b0;
        ore_b = o;
        minute_b = m;
        req_b = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (ack_b || err_b) done = 1'b1;
        end
        req_b = 1'b0;
        chk("b_completed", int'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic int outs_vec();
        return int'({busy, load_1, load_2, ack_a, ack_b, err_a, err_b,
                     timp_ore1, timp_minute1, timp_ore2, timp_minute2});
    endfunction

    initial begin
        int g;
        int nbusy;
        total = 0;
        bad = 0;
        stuck = 1'b0;
        tick_mode = 1'b0;
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        ore_a = '0;
        minute_a = '0;
        ore_b = '0;
        minute_b = '0;
        @(negedge clock);
        do_reset();
        chk("reset_outputs", outs_vec(), 0);

        // A alone, 12:35: the grant cycle through the ack cycle spans LOAD_LAT+3 cycles.
        g = cyc;
        push(K_L1, 12, 35, g + 1);
        push(K_ACKA, 0, 0, g + LOAD_LAT + 2);
        run_a(5'd12, 6'd35);
        chk("held_ore1", int'(timp_ore1), 12);
        chk("held_minute1", int'(timp_minute1), 35);
        repeat (3) @(negedge clock);

        // Simultaneous requests after reset: A first, then B.
        do_reset();
        push(K_L1, 8, 0, -1);
        push(K_ACKA, 0, 0, -1);
        push(K_L2, 17, 30, -1);
        push(K_ACKB, 0, 0, -1);
        fork
            run_a(5'd8, 6'd0);
            run_b(5'd17, 6'd30);
        join
        repeat (3) @(negedge clock);
        chk("held_ore2", int'(timp_ore2), 17);
        chk("held_minute2", int'(timp_minute2), 30);

        // Out-of-range hour: immediate error, no load, busy for one cycle.
        push(K_ERRA, 0, 0, cyc + 1);
        nbusy = 0;
        fork
            run_a(5'd24, 6'd10);
            begin
                repeat (6) begin
                    @(negedge clock);
                    if (busy) nbusy++;
                end
            end
        join
        chk("invalid_busy_cycles", nbusy, 1);
        repeat (2) @(negedge clock);

        // Counter ignores loads: 1 + MAX_RETRY load attempts, then error.
        stuck = 1'b1;
        ore = 5'd0;
        minute = 6'd0;
        push(K_L1, 9, 15, -1);
        push(K_L1, 9, 15, -1);
        push(K_L1, 9, 15, -1);
        push(K_ERRA, 0, 0, -1);
        run_a(5'd9, 6'd15);
        stuck = 1'b0;
        repeat (3) @(negedge clock);

        // Counter ticks 10:59 -> 11:00 before the readback.
        tick_mode = 1'b1;
        push(K_L1, 10, 59, -1);
        push(K_ACKA, 0, 0, -1);
        run_a(5'd10, 6'd59);
        tick_mode = 1'b0;
        repeat (3) @(negedge clock);

        // Reset while waiting on the counter: abort silently.
        push(K_L1, 12, 0, -1);
        ore_a = 5'd12;
        minute_a = 6'd0;
        req_a = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("busy_in_wait", int'(busy), 1);
        reset = 1'b1;
        req_a = 1'b0;
        @(negedge clock);
        chk("abort_outputs", outs_vec(), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("abort_no_pending", exp_q.size(), 0);

        // After the abort A still wins the first conflict.
        push(K_L1, 1, 2, -1);
        push(K_ACKA, 0, 0, -1);
        push(K_L2, 3, 4, -1);
        push(K_ACKB, 0, 0, -1);
        fork
            run_a(5'd1, 6'd2);
            run_b(5'd3, 6'd4);
        join
        repeat (4) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
